// File: rtl/systolic_weight_arbiter.sv
// systolic_weight_arbiter: round-robin owner of one weight-tile source shared by NUM_REQ slave controllers
//
// Grants the weight source to one requester at a time for exactly one BURST_LEN-beat tile,
// pulses a fetch command to the weight fetcher, then steers the tile's beats to the owner only.
//
// Ports:
//   s_clk, s_rst     clock, asynchronous active-high reset
//   i_req            per-requester tile request (level, held until its last-beat handshake)
//   o_grant          one-hot current owner, zero when idle
//   o_fetch_start    one-cycle fetch command to the weight fetcher
//   o_fetch_id       owner index, valid with o_fetch_start
//   i_src_valid      source beat valid
//   i_src_data       source beat
//   o_src_ready      source beat accepted
//   o_dst_valid      per-requester beat valid (owner bit only)
//   o_dst_data       beat data shared by all requesters
//   o_dst_last       final beat of the tile, qualified by o_dst_valid
//   i_dst_ready      per-requester ready
//   o_busy           arbiter not idle
module systolic_weight_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 32,
    parameter int CNT_W      = 6
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic [NUM_REQ-1:0]    i_req,
    output logic [NUM_REQ-1:0]    o_grant,
    output logic                  o_fetch_start,
    output logic [2:0]            o_fetch_id,
    input  logic                  i_src_valid,
    input  logic [DATA_WIDTH-1:0] i_src_data,
    output logic                  o_src_ready,
    output logic [NUM_REQ-1:0]    o_dst_valid,
    output logic [DATA_WIDTH-1:0] o_dst_data,
    output logic [NUM_REQ-1:0]    o_dst_last,
    input  logic [NUM_REQ-1:0]    i_dst_ready,
    output logic                  o_busy
);
    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_FETCH, S_STREAM, S_DONE} state_t;

    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [3:0]         NR4       = 4'(NUM_REQ);
    localparam logic [2:0]         LAST_IDX  = 3'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       count;
    logic [2:0]             rr_ptr;
    logic [2:0]             win_idx;
    logic [2:0]             rr_win;
    logic                   rr_found;
    logic [3:0]             rr_sum;
    logic [2*NUM_REQ-1:0]   req_rot;
    logic                   streaming;
    logic                   beat_hs;
    logic                   beat_last;

    // Rotating the doubled request vector by rr_ptr puts the search start at bit 0,
    // so the lowest set bit is the first requester at or after the pointer.
    always_comb begin
        req_rot  = {i_req, i_req} >> rr_ptr;
        rr_found = 1'b0;
        rr_win   = '0;
        rr_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rr_found && req_rot[i]) begin
                rr_found = 1'b1;
                rr_sum   = {1'b0, rr_ptr} + 4'(i);
                rr_win   = 3'((rr_sum >= NR4) ? rr_sum - NR4 : rr_sum);
            end
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        streaming   = (state == S_STREAM);
        o_busy      = (state != S_IDLE);
        o_src_ready = streaming && |(o_grant & i_dst_ready);
        o_dst_valid = streaming ? (o_grant & {NUM_REQ{i_src_valid}}) : '0;
        o_dst_data  = streaming ? i_src_data : '0;
        o_dst_last  = (count == LAST_BEAT) ? o_dst_valid : '0;
        beat_hs     = i_src_valid && o_src_ready;
        beat_last   = beat_hs && (count == LAST_BEAT);
        case (state)
            S_IDLE:   state_nxt = |i_req ? S_GRANT : S_IDLE;
            // A request withdrawn before this cycle gives no grant.
            S_GRANT:  state_nxt = rr_found ? S_FETCH : S_IDLE;
            S_FETCH:  state_nxt = S_STREAM;
            S_STREAM: state_nxt = beat_last ? S_DONE : S_STREAM;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The fetch pulse is registered out of S_FETCH, so it coincides with the
    // first S_STREAM cycle; the fetcher's first beat can arrive from then on.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            o_grant       <= '0;
            o_fetch_start <= 1'b0;
            o_fetch_id    <= '0;
            count         <= '0;
            rr_ptr        <= '0;
            win_idx       <= '0;
        end else begin
            o_fetch_start <= (state == S_FETCH);
            if (state == S_GRANT && rr_found) begin
                o_grant <= ONE << rr_win;
                win_idx <= rr_win;
            end
            if (state == S_FETCH)
                o_fetch_id <= win_idx;
            if (beat_hs)
                count <= beat_last ? '0 : count + 1'b1;
            if (beat_last)
                rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + 3'd1;
            if (state == S_DONE)
                o_grant <= '0;
        end
    end
endmodule
